req_capture4: RTL and testbench
===============================

# req_capture4

Upstream request-capture stage for the 4-input priority encoder. It latches edge- or level-triggered requests into pending bits and applies a mask. It presents a frozen snapshot of the unmasked pending vector to the encoder under a valid/ack handshake. Each acknowledgement returns the encoded index, which clears exactly one pending bit; lost (overrun) requests are flagged per line.

## Interface
- EDGE_MODE, 1, 1 = a rising edge on req_in sets pending; 0 = a high level on req_in sets pending every cycle
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- req_in  in  4  raw request lines, synchronous to clk
- mask  in  4  1 = line not offered (still latched)
- pend_out  out  4  snapshot vector to encoder; bit 3 is highest priority downstream
- pend_valid  out  1  snapshot valid
- ack_valid  in  1  consumer acknowledges; sampled only while pend_valid=1
- ack_idx  in  2  index being acknowledged (encoder output)
- ack_err  out  1  one-cycle pulse: ack_idx not set in snapshot
- overrun  out  4  sticky per-line lost-request flags
- ovr_clr  in  4  write-1-to-clear for overrun

## Operation
- Registers: prev_req[3:0], pending[3:0], snap[3:0], overrun[3:0], state.
- Set term: EDGE_MODE=1 → req_in & ~prev_req; EDGE_MODE=0 → req_in.
- FSM states: IDLE, OFFER.
  - IDLE: if (pending & ~mask) != 0, load snap ← pending & ~mask and go to OFFER.
  - OFFER: snap is frozen. pend_out = snap and pend_valid = 1.
  - OFFER with ack_valid=1 and snap[ack_idx]=1: clear pending[ack_idx] and go to IDLE.
  - OFFER with ack_valid=1 and snap[ack_idx]=0: pulse ack_err, clear nothing, stay in OFFER.
- pend_out = 0 when not in OFFER.
- Mask changes while in OFFER do not alter snap. They take effect at the next IDLE load.
- Same cycle, same line, set term and ack-clear: set wins. pending stays 1 and overrun is not set.
- Set term on a line whose pending=1 and which is not being cleared this cycle: overrun[line] ← 1.
  - In EDGE_MODE=0 a held level never raises overrun. Overrun applies to edges only.
- ovr_clr[i] clears overrun[i] unless a new overrun event occurs on i in the same cycle; the event wins.

## Timing
- Reset, synchronous, held ≥1 cycle:
  - pending=0, snap=0, overrun=0, state=IDLE.
  - pend_out=0, pend_valid=0, ack_err=0.
  - prev_req ← req_in during reset, so a line already high at reset release is not an edge.
- Reset mid-OFFER: the next cycle shows pend_valid=0. Any in-flight ack is discarded.
- Request edge sampled at edge t: pending set at t. The IDLE→OFFER load happens at t+1, so pend_valid=1 is visible after edge t+1. Request-to-offer latency is 2 cycles.
- Ack at edge t in OFFER:
  - pending bit cleared and IDLE at t.
  - If other unmasked bits remain, OFFER again at t+1.
  - Back-to-back service costs 2 cycles per request.
- ack_err is registered and high for exactly the cycle after the bad ack.
- Back-pressure: the consumer may hold off ack indefinitely. New requests accumulate in pending, not in snap.

## Structure
- Shared package `req_capture_pkg`:
  - state enum (IDLE, OFFER)
  - constant N_REQ = 4
  - index width IDX_W = 2
- Sub-module `edge_detect4`: the prev_req register plus set-term generation, with EDGE_MODE passed through. The FSM, pending/snap and overrun logic stay in the top module.

## Test plan
- Reset with req_in=4'b0100 held high, then release → no pending and pend_valid=0 for 5 cycles; drop and re-raise bit 2 → pend_out=4'b0100 two cycles after the rise.
- Edges on bits 3 and 0 in the same cycle → pend_out=4'b1001. Ack idx 3 → next offer is 4'b0001. Ack idx 0 → pend_valid=0.
- mask=4'b0010 and edge on bit 1 → no offer. Clear the mask → pend_out=4'b0010 on the next IDLE cycle.
- While in OFFER with snap=4'b0100, ack idx 1 → ack_err pulses for one cycle, state stays OFFER, pending is unchanged.
- Second edge on bit 2 while pending[2]=1 → overrun=4'b0100. ovr_clr=4'b0100 → 0. A new edge on bit 2 in the same cycle as its ack → pending stays 1 and overrun stays 0.
- EDGE_MODE=0 with bit 1 held high → re-offered after every ack and overrun never set. Assert rst during OFFER → pend_valid=0 on the next cycle.

Source files
------------

// File: rtl/req_capture_pkg.sv
// req_capture_pkg: shared types and sizes for the request-capture stage
package req_capture_pkg;
    localparam int N_REQ = 4;
    localparam int IDX_W = 2;
    typedef enum logic {IDLE, OFFER} state_t;
endpackage

// File: rtl/edge_detect4.sv
// edge_detect4: turns raw request lines into per-line set terms
// ports: clk; req_in raw lines; set_term one pulse per rising edge (EDGE_MODE=1) or the level itself (EDGE_MODE=0)
module edge_detect4
    import req_capture_pkg::*;
#(
    parameter bit EDGE_MODE = 1'b1
) (
    input  logic             clk,
    input  logic [N_REQ-1:0] req_in,
    output logic [N_REQ-1:0] set_term
);
    logic [N_REQ-1:0] prev_req;
    // prev_req tracks req_in through reset too, so a line held high across release is not an edge
    always_ff @(posedge clk) prev_req <= req_in;
    assign set_term = EDGE_MODE ? (req_in & ~prev_req) : req_in;
endmodule

// File: rtl/req_capture4.sv
// req_capture4: latches requests into pending bits and offers a frozen masked snapshot under a valid/ack handshake
// ports: clk, rst (sync, active-high); req_in raw lines; mask (1 = not offered);
//        pend_out/pend_valid snapshot to encoder; ack_valid/ack_idx acknowledgement;
//        ack_err one-cycle pulse on ack of a bit not in the snapshot; overrun sticky lost-request flags, ovr_clr W1C
module req_capture4
    import req_capture_pkg::*;
#(
    parameter bit EDGE_MODE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_in,
    input  logic [N_REQ-1:0] mask,
    output logic [N_REQ-1:0] pend_out,
    output logic             pend_valid,
    input  logic             ack_valid,
    input  logic [IDX_W-1:0] ack_idx,
    output logic             ack_err,
    output logic [N_REQ-1:0] overrun,
    input  logic [N_REQ-1:0] ovr_clr
);
    state_t state, state_nxt;
    logic [N_REQ-1:0] pending, snap, set_term, clr, ovr_ev, offer;
    logic ack_ok, ack_bad;

    edge_detect4 #(.EDGE_MODE(EDGE_MODE)) u_edge (
        .clk     (clk),
        .req_in  (req_in),
        .set_term(set_term)
    );

    assign offer   = pending & ~mask;
    assign ack_ok  = (state == OFFER) && ack_valid && snap[ack_idx];
    assign ack_bad = (state == OFFER) && ack_valid && !snap[ack_idx];
    assign clr     = ack_ok ? (N_REQ'(1) << ack_idx) : '0;
    // a set landing on a line being cleared this cycle just keeps it pending; a held level is never a loss
    assign ovr_ev  = EDGE_MODE ? (set_term & pending & ~clr) : '0;

    always_comb begin
        state_nxt = (state == IDLE) ? (|offer ? OFFER : IDLE) : (ack_ok ? IDLE : OFFER);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            snap    <= '0;
            overrun <= '0;
            ack_err <= 1'b0;
        end else begin
            pending <= (pending & ~clr) | set_term;
            if (state == IDLE && |offer) snap <= offer;
            overrun <= (overrun & ~ovr_clr) | ovr_ev;
            ack_err <= ack_bad;
        end
    end

    assign pend_valid = (state == OFFER);
    assign pend_out   = pend_valid ? snap : '0;
endmodule

// File: tb/tb_req_capture4.sv
// tb_req_capture4: scoreboard bench for req_capture4 in edge and level modes
module tb_req_capture4;
    logic       clk, rst, ack_valid;
    logic [3:0] req_in, mask, ovr_clr;
    logic [1:0] ack_idx;
    logic [3:0] po_e, ovr_e, po_l, ovr_l;
    logic       pv_e, err_e, pv_l, err_l;
    logic       pv_e_d, pv_l_d, mon_e, mon_l;
    logic [3:0] exp_e[$];
    logic [3:0] exp_l[$];
    int n_chk, n_pass;

    req_capture4 #(.EDGE_MODE(1'b1)) dut (
        .clk(clk), .rst(rst), .req_in(req_in), .mask(mask),
        .pend_out(po_e), .pend_valid(pv_e), .ack_valid(ack_valid), .ack_idx(ack_idx),
        .ack_err(err_e), .overrun(ovr_e), .ovr_clr(ovr_clr)
    );

    req_capture4 #(.EDGE_MODE(1'b0)) dut_l (
        .clk(clk), .rst(rst), .req_in(req_in), .mask(mask),
        .pend_out(po_l), .pend_valid(pv_l), .ack_valid(ack_valid), .ack_idx(ack_idx),
        .ack_err(err_l), .overrun(ovr_l), .ovr_clr(ovr_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_valid(input bit lvl);
        for (int i = 0; i < 10; i++) begin
            if (lvl ? pv_l : pv_e) return;
            tick();
        end
        n_chk++;
        $display("FAIL wait_valid: got no offer expected offer within 10 cycles");
    endtask

    task automatic ack(input logic [1:0] idx);
        ack_valid = 1'b1;
        ack_idx   = idx;
        tick();
        ack_valid = 1'b0;
    endtask

    // monitor: every new offer (rising pend_valid) is matched against the next queued snapshot
    initial begin
        pv_e_d = 1'b0;
        pv_l_d = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_e && pv_e && !pv_e_d) begin
                if (exp_e.size() == 0) begin
                    n_chk++;
                    $display("FAIL offer_e: got unexpected offer %b expected none", po_e);
                end else chk("offer_e", po_e, exp_e.pop_front());
            end
            if (mon_l && pv_l && !pv_l_d) begin
                if (exp_l.size() == 0) begin
                    n_chk++;
                    $display("FAIL offer_l: got unexpected offer %b expected none", po_l);
                end else chk("offer_l", po_l, exp_l.pop_front());
            end
            pv_e_d = pv_e;
            pv_l_d = pv_l;
        end
    end

    initial begin
        n_chk = 0; n_pass = 0;
        mon_e = 1'b1; mon_l = 1'b0;
        rst = 1'b1; req_in = 4'b0100; mask = 4'b0; ovr_clr = 4'b0;
        ack_valid = 1'b0; ack_idx = 2'd0;
        tick(); tick();
        chk("rst_pv", {3'b0, pv_e}, 4'b0);
        chk("rst_po", po_e, 4'b0);
        chk("rst_err", {3'b0, err_e}, 4'b0);
        chk("rst_ovr", ovr_e, 4'b0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("held_no_offer", {3'b0, pv_e}, 4'b0);
        end
        req_in = 4'b0000;
        tick();
        exp_e.push_back(4'b0100);
        req_in = 4'b0100;
        tick();
        chk("lat_1", {3'b0, pv_e}, 4'b0);
        tick();
        chk("lat_2", {3'b0, pv_e}, 4'b1);
        req_in = 4'b0000;
        ack(2'd2);
        chk("ack2_idle", {3'b0, pv_e}, 4'b0);

        exp_e.push_back(4'b1001);
        exp_e.push_back(4'b0001);
        req_in = 4'b1001;
        tick();
        req_in = 4'b0000;
        tick();
        wait_valid(1'b0);
        ack(2'd3);
        chk("ack3_idle", {3'b0, pv_e}, 4'b0);
        wait_valid(1'b0);
        ack(2'd0);
        chk("ack0_idle", {3'b0, pv_e}, 4'b0);
        tick();
        chk("ack0_stay", {3'b0, pv_e}, 4'b0);

        mask = 4'b0010;
        req_in = 4'b0010;
        tick();
        req_in = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("masked", {3'b0, pv_e}, 4'b0);
        end
        exp_e.push_back(4'b0010);
        mask = 4'b0000;
        tick();
        chk("unmask_offer", {3'b0, pv_e}, 4'b1);
        ack(2'd1);

        exp_e.push_back(4'b0100);
        req_in = 4'b0100;
        tick();
        req_in = 4'b0000;
        tick();
        wait_valid(1'b0);
        ack_valid = 1'b1;
        ack_idx = 2'd1;
        tick();
        ack_valid = 1'b0;
        chk("bad_ack_err", {3'b0, err_e}, 4'b1);
        chk("bad_ack_pv", {3'b0, pv_e}, 4'b1);
        chk("bad_ack_po", po_e, 4'b0100);
        tick();
        chk("err_pulse", {3'b0, err_e}, 4'b0);
        chk("err_stay", {3'b0, pv_e}, 4'b1);

        req_in = 4'b0100;
        tick();
        chk("ovr_set", ovr_e, 4'b0100);
        req_in = 4'b0000;
        ovr_clr = 4'b0100;
        tick();
        ovr_clr = 4'b0000;
        chk("ovr_clr", ovr_e, 4'b0000);
        exp_e.push_back(4'b0100);
        req_in = 4'b0100;
        ack_valid = 1'b1;
        ack_idx = 2'd2;
        tick();
        ack_valid = 1'b0;
        req_in = 4'b0000;
        chk("set_wins_ovr", ovr_e, 4'b0000);
        chk("set_wins_idle", {3'b0, pv_e}, 4'b0);
        tick();
        chk("set_wins_reoffer", {3'b0, pv_e}, 4'b1);
        ack(2'd2);
        chk("final_idle", {3'b0, pv_e}, 4'b0);
        tick();
        chk("final_stay", {3'b0, pv_e}, 4'b0);

        mon_e = 1'b0;
        rst = 1'b1;
        tick(); tick();
        chk("lvl_rst_pv", {3'b0, pv_l}, 4'b0);
        chk("lvl_rst_ovr", ovr_l, 4'b0);
        mon_l = 1'b1;
        for (int i = 0; i < 4; i++) exp_l.push_back(4'b0010);
        rst = 1'b0;
        req_in = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            wait_valid(1'b1);
            chk("lvl_ovr", ovr_l, 4'b0);
            ack(2'd1);
            chk("lvl_ack_idle", {3'b0, pv_l}, 4'b0);
        end
        wait_valid(1'b1);
        chk("lvl_ovr_end", ovr_l, 4'b0);
        rst = 1'b1;
        tick();
        chk("rst_mid_offer", {3'b0, pv_l}, 4'b0);
        rst = 1'b0;
        req_in = 4'b0000;
        tick();
        chk("exp_e_empty", 4'(exp_e.size()), 4'd0);
        chk("exp_l_empty", 4'(exp_l.size()), 4'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
